// File: rtl/masked_share_encoder.sv
// Splits unmasked bytes into three Boolean shares using masks from a 32-bit Galois LFSR,
// buffered in a 2-entry FIFO. Optional LFSR reseed port: define MASKED_SHARE_ENCODER_RESEED_EN.
module masked_share_encoder #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_1234
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MASKED_SHARE_ENCODER_RESEED_EN
  ,
  input  logic [31:0]      seed_in,
  input  logic             seed_valid
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and outputs hold while valid=1 and ready=0.

  localparam logic [31:0] TAPS     = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t             occ_q, occ_d;
  logic [31:0]      lfsr_q;
  logic [31:0]      lfsr_adv;
  logic [WIDTH-1:0] mask1, mask2;
  logic [WIDTH-1:0] enc1;
  logic [WIDTH-1:0] head1, head2, head3;
  logic [WIDTH-1:0] tail1, tail2, tail3;
  logic             push, pop;
  logic             load_head_enc, load_head_tail, load_tail;

  assign in_ready  = (occ_q != OCC_FULL) & rst_i;
  assign out_valid = (occ_q != OCC_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out1      = head1;
  assign out2      = head2;
  assign out3      = head3;

  // 2*WIDTH Galois steps unrolled; each step emits the LSB before shifting.
  always_comb begin
    logic [31:0] s;
    logic        b;
    s     = lfsr_q;
    b     = 1'b0;
    mask1 = '0;
    mask2 = '0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      b = s[0];
      if (i < WIDTH) mask1[i] = b;
      else           mask2[i - WIDTH] = b;
      s = {1'b0, s[31:1]} ^ (b ? TAPS : 32'd0);
    end
    lfsr_adv = s;
  end

  // Only the masked share is ever formed from raw data; it goes straight into the buffer.
  assign enc1 = in_data ^ mask1 ^ mask2;

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      lfsr_q <= SEED_EFF;
    end else begin
`ifdef MASKED_SHARE_ENCODER_RESEED_EN
      if (seed_valid)
        lfsr_q <= (seed_in == 32'd0) ? 32'd1 : seed_in;
      else if (push)
        lfsr_q <= lfsr_adv;
`else
      if (push)
        lfsr_q <= lfsr_adv;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_i) occ_q <= OCC_EMPTY;
    else        occ_q <= occ_d;
  end

  always_comb begin
    occ_d          = occ_q;
    load_head_enc  = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          load_head_enc = 1'b1;
          occ_d         = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          load_head_enc = 1'b1;
        end else if (push) begin
          load_tail = 1'b1;
          occ_d     = OCC_FULL;
        end else if (pop) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          load_head_tail = 1'b1;
          occ_d          = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      head1 <= '0;
      head2 <= '0;
      head3 <= '0;
      tail1 <= '0;
      tail2 <= '0;
      tail3 <= '0;
    end else begin
      if (load_head_enc) begin
        head1 <= enc1;
        head2 <= mask1;
        head3 <= mask2;
      end else if (load_head_tail) begin
        head1 <= tail1;
        head2 <= tail2;
        head3 <= tail3;
      end
      if (load_tail) begin
        tail1 <= enc1;
        tail2 <= mask1;
        tail3 <= mask2;
      end
    end
  end

endmodule

// File: tb/tb_masked_share_encoder.sv
// Randomized/directed bench for masked_share_encoder against a share-level reference model.
module tb_masked_share_encoder;

  localparam int          W    = 8;
  localparam logic [31:0] SEED = 32'hACE1_1234;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out1, out2, out3;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  seed_in;
  logic         seed_valid;

  logic [W-1:0] in_data_z;
  logic         in_valid_z;
  logic         in_ready_z;
  logic [W-1:0] out1_z, out2_z, out3_z;
  logic         out_valid_z;

  int n_vec = 0;
  int n_bad = 0;

  logic [3*W-1:0] exp_q[$];
  logic [3*W-1:0] exp_z_q[$];
  logic [31:0]    model_lfsr;
  logic [31:0]    model_lfsr_z;

  always #5 clk = ~clk;

  masked_share_encoder #(.WIDTH(W), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_i(rst_i), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out1(out1), .out2(out2), .out3(out3), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MASKED_SHARE_ENCODER_RESEED_EN
    , .seed_in(seed_in), .seed_valid(seed_valid)
`endif
  );

  masked_share_encoder #(.WIDTH(W), .LFSR_SEED(32'd0)) dut_zero (
    .clk(clk), .rst_i(rst_i), .in_data(in_data_z), .in_valid(in_valid_z), .in_ready(in_ready_z),
    .out1(out1_z), .out2(out2_z), .out3(out3_z), .out_valid(out_valid_z), .out_ready(1'b1)
`ifdef MASKED_SHARE_ENCODER_RESEED_EN
    , .seed_in(32'd0), .seed_valid(1'b0)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mask stream: 16 output bits of the LFSR, LSB emitted before each step.
  task automatic gen_masks(input logic [31:0] s_in, output logic [W-1:0] m1,
                           output logic [W-1:0] m2, output logic [31:0] s_out);
    logic [31:0] s;
    logic        b;
    s = s_in;
    for (int k = 0; k < 2 * W; k++) begin
      b = s[0];
      if (k < W) m1[k] = b;
      else       m2[k - W] = b;
      s = (s >> 1) ^ (b ? 32'h8020_0003 : 32'd0);
    end
    s_out = s;
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model at the edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic rst_n);
    logic         exp_rdy, acc, popd;
    logic [W-1:0] m1, m2;
    logic [31:0]  ns;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    rst_i     = rst_n;
    @(negedge clk);
    exp_rdy = rst_n && (exp_q.size() < 2);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) chk("shares", {40'd0, out1, out2, out3}, {40'd0, exp_q[0]});
    acc  = v && exp_rdy;
    popd = r && (exp_q.size() > 0);
    if (!rst_n) begin
      exp_q.delete();
      model_lfsr = SEED;
    end else begin
      if (popd) void'(exp_q.pop_front());
      if (acc) begin
        gen_masks(model_lfsr, m1, m2, ns);
        exp_q.push_back({d ^ m1 ^ m2, m1, m2});
      end
      if (seed_valid) model_lfsr = (seed_in == 32'd0) ? 32'd1 : seed_in;
      else if (acc)   model_lfsr = ns;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int zp_model, zp_dut;
    logic [W-1:0] m1, m2;
    logic [31:0]  ns;
    logic [W-1:0] dz;

    rst_i = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    seed_in = '0; seed_valid = 1'b0; in_valid_z = 1'b0; in_data_z = '0;
    model_lfsr = SEED;
    model_lfsr_z = 32'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_shares", {40'd0, out1, out2, out3}, 64'd0);

    // Basic encoding, one word per cycle.
    step(1'b1, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    step(1'b1, 8'h5A, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);

    // Back-pressure: third word stalls until space frees up.
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b1, 1'b1);
    step(1'b1, 8'h33, 1'b1, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b1);

    // Simultaneous push/pop at occupancy 1.
    step(1'b1, 8'($urandom), 1'b0, 1'b1);
    repeat (10) step(1'b1, 8'($urandom), 1'b1, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b1, 1'b1);

    // Reset with two words buffered.
    step(1'b1, 8'hA1, 1'b0, 1'b1);
    step(1'b1, 8'hB2, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("post_rst_shares", {40'd0, out1, out2, out3}, 64'd0);
    step(1'b1, 8'hC3, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);

`ifdef MASKED_SHARE_ENCODER_RESEED_EN
    seed_in = 32'hDEAD_BEEF; seed_valid = 1'b1;
    step(1'b1, 8'h77, 1'b1, 1'b1);
    seed_valid = 1'b0;
    step(1'b1, 8'h88, 1'b1, 1'b1);
    seed_in = 32'd0; seed_valid = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b1);
    seed_valid = 1'b0;
    step(1'b1, 8'h99, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
`endif

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
`ifdef MASKED_SHARE_ENCODER_RESEED_EN
      seed_valid = ($urandom_range(0, 15) == 0);
      seed_in    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
`endif
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 60) != 0));
    end
    seed_valid = 1'b0;
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b1);

    // Zero-seed instance: 1000 back-to-back words from the replacement seed 1.
    zp_model = 0;
    zp_dut   = 0;
    exp_z_q.delete();
    for (int i = 0; i < 1003; i++) begin
      in_valid_z = (i < 1000);
      dz         = 8'($urandom);
      in_data_z  = dz;
      @(negedge clk);
      chk("z_out_valid", {63'd0, out_valid_z}, {63'd0, exp_z_q.size() > 0});
      if (exp_z_q.size() > 0) begin
        chk("z_shares", {40'd0, out1_z, out2_z, out3_z}, {40'd0, exp_z_q[0]});
        if (out2_z == '0 && out3_z == '0) zp_dut++;
        void'(exp_z_q.pop_front());
      end
      if (in_valid_z && exp_z_q.size() < 2) begin
        gen_masks(model_lfsr_z, m1, m2, ns);
        if (m1 == '0 && m2 == '0) zp_model++;
        exp_z_q.push_back({dz ^ m1 ^ m2, m1, m2});
        model_lfsr_z = ns;
      end
      @(posedge clk);
      #1;
    end
    chk("z_zero_pairs", 64'(zp_dut), 64'(zp_model));
    chk("z_drained", 64'(exp_z_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
